// File: rtl/regfile_pkg.sv
// Shared types and default sizes for the integer register file.
package regfile_pkg;

  localparam int unsigned XLEN_DEF = 32;
  localparam int unsigned NREG_DEF = 32;
  localparam int unsigned AW_DEF   = 5;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;

endpackage

// File: rtl/regfile_clr_seq.sv
// Clear sequencer: walks registers 1..NREG-1 once per clr_req, one per cycle.
module regfile_clr_seq
  import regfile_pkg::*;
#(
  parameter int unsigned NREG = NREG_DEF,
  parameter int unsigned AW   = AW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_req,
  output logic          clr_busy,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(NREG - 1);

  clr_state_e    state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Counter holds at LAST_ADDR on exit so it never wraps.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d = CLEAR;
          cnt_d   = AW'(1);
        end
      end
      CLEAR: begin
        if (cnt_q == LAST_ADDR) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign clr_busy = (state_q == CLEAR);
  assign clr_we   = (state_q == CLEAR);
  assign clr_addr = cnt_q;

endmodule

// File: rtl/regfile_2r1w.sv
// Integer register file: 2 combinational reads, 1 synchronous write, x0 = 0,
// optional write-to-read bypass and an in-band clear sequencer.
module regfile_2r1w
  import regfile_pkg::*;
#(
  parameter int unsigned     XLEN   = XLEN_DEF,
  parameter int unsigned     NREG   = NREG_DEF,
  parameter int unsigned     AW     = AW_DEF,
  parameter logic [XLEN-1:0] INIVAL = '0,
  parameter bit              BYPASS = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [AW-1:0]   raddr1,
  output logic [XLEN-1:0] rdata1,
  input  logic [AW-1:0]   raddr2,
  output logic [XLEN-1:0] rdata2,
  input  logic            clr_req,
  output logic            clr_busy
);

  logic [XLEN-1:0] regs_q [1:NREG-1];

  logic            clr_we;
  logic [AW-1:0]   clr_addr;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [XLEN-1:0] wr_data;
  logic            user_wr_ok;
  logic            byp_ok;

  regfile_clr_seq #(
    .NREG (NREG),
    .AW   (AW)
  ) u_clr_seq (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_req  (clr_req),
    .clr_busy (clr_busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  function automatic logic addr_valid(input logic [AW-1:0] a);
    return (a != '0) && (32'(a) < NREG);
  endfunction

  assign user_wr_ok = we && !clr_busy && addr_valid(waddr);
  assign byp_ok     = BYPASS && we && !clr_busy;

  // The clear sequencer owns the write port while busy; user writes are dropped.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    if (clr_we) begin
      wr_en   = 1'b1;
      wr_addr = clr_addr;
      wr_data = INIVAL;
    end else if (user_wr_ok) begin
      wr_en   = 1'b1;
      wr_addr = waddr;
      wr_data = wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 1; i < NREG; i++) begin
        regs_q[i] <= INIVAL;
      end
    end else if (wr_en) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rdata1 = '0;
    if (addr_valid(raddr1)) begin
      if (byp_ok && (waddr == raddr1)) begin
        rdata1 = wdata;
      end else begin
        rdata1 = regs_q[raddr1];
      end
    end
  end

  always_comb begin
    rdata2 = '0;
    if (addr_valid(raddr2)) begin
      if (byp_ok && (waddr == raddr2)) begin
        rdata2 = wdata;
      end else begin
        rdata2 = regs_q[raddr2];
      end
    end
  end

endmodule

// File: tb/tb_regfile_2r1w.sv
// Bench for regfile_2r1w: two instances (full/bypass, reduced/no-bypass) against
// an array-based reference model, directed scenarios then random traffic.
module tb_regfile_2r1w;

  localparam logic [31:0] INI_B = 32'hCAFE_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  raddr1, raddr2;
  logic        clr_req;
  logic [31:0] rd1_a, rd2_a, rd1_b, rd2_b;
  logic        busy_a, busy_b;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  regfile_2r1w #(.XLEN(32), .NREG(32), .AW(5), .INIVAL(32'h0), .BYPASS(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr1(raddr1), .rdata1(rd1_a), .raddr2(raddr2), .rdata2(rd2_a),
    .clr_req(clr_req), .clr_busy(busy_a)
  );

  regfile_2r1w #(.XLEN(32), .NREG(24), .AW(5), .INIVAL(INI_B), .BYPASS(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr1(raddr1), .rdata1(rd1_b), .raddr2(raddr2), .rdata2(rd2_b),
    .clr_req(clr_req), .clr_busy(busy_b)
  );

  // Reference model: index 0 = instance A, 1 = instance B.
  logic [31:0] mdl [2][32];
  int          nreg_m [2] = '{32, 24};
  bit          byp_m  [2] = '{1'b1, 1'b0};
  logic [31:0] ini_m  [2] = '{32'h0, INI_B};
  int          clr_pos[2];   // 0 = idle, else the register cleared at the next edge
  logic        last_busy_a;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_rd(input int m, input logic [4:0] a);
    if (a == 5'd0 || int'(a) >= nreg_m[m]) return 32'h0;
    if (byp_m[m] && we && clr_pos[m] == 0 && waddr == a) return wdata;
    return mdl[m][a];
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      for (int a = 0; a < 32; a++) mdl[m][a] = ini_m[m];
      clr_pos[m] = 0;
    end
  endtask

  task automatic model_edge();
    for (int m = 0; m < 2; m++) begin
      if (clr_pos[m] != 0) begin
        mdl[m][clr_pos[m]] = ini_m[m];
        clr_pos[m] = (clr_pos[m] == nreg_m[m] - 1) ? 0 : clr_pos[m] + 1;
      end else begin
        if (we && waddr != 5'd0 && int'(waddr) < nreg_m[m]) mdl[m][waddr] = wdata;
        if (clr_req) clr_pos[m] = 1;
      end
    end
  endtask

  task automatic check_outputs();
    check_eq("a_rdata1", rd1_a, exp_rd(0, raddr1));
    check_eq("a_rdata2", rd2_a, exp_rd(0, raddr2));
    check_eq("b_rdata1", rd1_b, exp_rd(1, raddr1));
    check_eq("b_rdata2", rd2_b, exp_rd(1, raddr2));
    check_eq("a_busy", {31'b0, busy_a}, {31'b0, clr_pos[0] != 0});
    check_eq("b_busy", {31'b0, busy_b}, {31'b0, clr_pos[1] != 0});
  endtask

  // Check the pre-edge view at negedge, then advance the model across the edge.
  task automatic cycle();
    @(negedge clk);
    check_outputs();
    last_busy_a = busy_a;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    we = 1'b0; waddr = '0; wdata = '0; clr_req = 1'b0;
  endtask

  // Pulse clr_req and count the cycles clr_busy on instance A stays high.
  task automatic run_clear(input string tag);
    int cnt;
    clr_req = 1'b1;
    cycle();
    clr_req = 1'b0;
    cnt = 0;
    for (int g = 0; g < 100; g++) begin
      cycle();
      if (!last_busy_a) break;
      cnt++;
    end
    check_eq(tag, 32'(cnt), 32'd31);
  endtask

  initial begin
    int cnt;
    rst_n = 1'b0;
    raddr1 = '0; raddr2 = '0;
    idle_inputs();
    model_reset();
    #12;
    check_outputs();
    #5 rst_n = 1'b1;
    @(posedge clk); #1;

    // Sweep every address on both ports after reset.
    for (int i = 0; i < 32; i++) begin
      raddr1 = 5'(i); raddr2 = 5'(31 - i);
      cycle();
    end

    // Same-cycle write/read of x5: bypass on A, old value on B.
    we = 1'b1; waddr = 5'd5; wdata = 32'hDEAD_BEEF; raddr1 = 5'd5; raddr2 = 5'd4;
    cycle();
    we = 1'b0;
    cycle();

    // Write to x0 with both ports reading x0 in a bypass-eligible cycle.
    we = 1'b1; waddr = 5'd0; wdata = 32'h1234_5678; raddr1 = 5'd0; raddr2 = 5'd0;
    cycle();
    we = 1'b0;
    cycle();

    // Writes beyond instance B's range, read back beyond its range.
    we = 1'b1; waddr = 5'd26; wdata = 32'h0BAD_F00D; raddr1 = 5'd26; raddr2 = 5'd23;
    cycle();
    we = 1'b0;
    cycle();

    // Fill x1..x31 with their index.
    for (int i = 1; i < 32; i++) begin
      we = 1'b1; waddr = 5'(i); wdata = 32'(i); raddr1 = 5'(i); raddr2 = 5'(i - 1);
      cycle();
    end
    idle_inputs();

    // Clear: x3 watched on port 1, x7 on port 2; a write to x7 mid-clear is dropped.
    raddr1 = 5'd3; raddr2 = 5'd7;
    clr_req = 1'b1;
    cycle();
    clr_req = 1'b0;
    cnt = 0;
    for (int g = 0; g < 100; g++) begin
      if (g == 4) begin
        we = 1'b1; waddr = 5'd7; wdata = 32'h7777_7777; clr_req = 1'b1;
      end else begin
        we = 1'b0; clr_req = 1'b0;
      end
      cycle();
      if (!last_busy_a) break;
      cnt++;
    end
    check_eq("clr_busy_len", 32'(cnt), 32'd31);
    idle_inputs();
    cycle();

    // clr_req together with a write to x2: the write lands, then is cleared.
    we = 1'b1; waddr = 5'd2; wdata = 32'hA5A5_A5A5; clr_req = 1'b1; raddr1 = 5'd2; raddr2 = 5'd2;
    cycle();
    idle_inputs();
    for (int g = 0; g < 40; g++) cycle();

    // Refill, start a clear, then reset asynchronously at clear cycle 10.
    for (int i = 1; i < 32; i++) begin
      we = 1'b1; waddr = 5'(i); wdata = $urandom; raddr1 = 5'(i); raddr2 = 5'(32 - i);
      cycle();
    end
    idle_inputs();
    clr_req = 1'b1;
    cycle();
    clr_req = 1'b0;
    for (int g = 0; g < 10; g++) cycle();
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    raddr1 = 5'd20; raddr2 = 5'd9;
    #1;
    check_outputs();
    #1 rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      raddr1 = 5'(i); raddr2 = 5'(i + 16);
      cycle();
    end
    run_clear("clr_after_rst_len");

    // Random traffic with occasional clears.
    for (int g = 0; g < 400; g++) begin
      we      = 1'($urandom_range(0, 1));
      waddr   = 5'($urandom_range(0, 31));
      wdata   = $urandom;
      raddr1  = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
      raddr2  = 5'($urandom_range(0, 31));
      clr_req = ($urandom_range(0, 49) == 0);
      cycle();
    end
    idle_inputs();
    for (int g = 0; g < 40; g++) cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/regfile_2r1w.md
# regfile_2r1w

Parametrised integer register file for the CORE: NREG words of XLEN bits, two combinational read ports, one synchronous write port. Register 0 is hardwired to zero. Optional same-cycle write-to-read bypass. A built-in clear sequencer returns every register to INIVAL on request without asserting reset. It sits between decode (read addresses) and writeback (write port) and replaces the per-register storage cells used so far.

## Interface
- XLEN, 32, data width in bits
- NREG, 32, number of registers (2..64)
- AW, 5, address width; must satisfy 2^AW >= NREG
- INIVAL, {XLEN{1'b0}}, reset and clear value of registers 1..NREG-1
- BYPASS, 1, 1 = write data forwarded to a same-cycle read of the same address; 0 = no forwarding

- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- we  in  1  write enable
- waddr  in  AW  write address
- wdata  in  XLEN  write data
- raddr1  in  AW  read address, port 1
- rdata1  out  XLEN  read data, port 1
- raddr2  in  AW  read address, port 2
- rdata2  out  XLEN  read data, port 2
- clr_req  in  1  clear request, single-cycle pulse
- clr_busy  out  1  clear sequence in progress

## Operation
- Reset: registers 1..NREG-1 = INIVAL; FSM = IDLE; clr_busy = 0; rdataN = 0 for address 0, otherwise INIVAL.
- Write: in IDLE, at posedge with we=1 and waddr != 0, reg[waddr] <= wdata. Writes to address 0 are ignored. Writes with waddr >= NREG are ignored.
- Read: combinational.
  - rdataN = 0 if raddrN == 0 or raddrN >= NREG.
  - Otherwise, if BYPASS=1, we=1, FSM=IDLE, and waddr == raddrN, rdataN = wdata.
  - Otherwise rdataN = reg[raddrN].
  - Both ports may read the same address.
- FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR at a posedge with clr_req=1; counter <= 1.
  - In CLEAR, each posedge: reg[counter] <= INIVAL, counter++.
  - The edge that clears register NREG-1 returns the FSM to IDLE.
- During CLEAR:
  - we is ignored: the write is dropped, not queued. The caller must stall on clr_busy.
  - The bypass is disabled.
  - Reads return stored contents, a mix of cleared and not-yet-cleared registers.
  - clr_req is ignored.
- clr_req and we in the same IDLE cycle: the write is performed at that edge, and the register is then cleared by the sequence.
- rst_n asserted mid-clear: immediate return to IDLE, all registers = INIVAL, clr_busy = 0.

## Timing
- Write latency: 1 edge. With BYPASS=1 the value is visible on a matching read in the same cycle. With BYPASS=0 it is visible the cycle after the edge.
- Read latency: 0 cycles (combinational from raddrN and state).
- clr_busy is registered. It rises after the edge that samples clr_req and stays high for exactly NREG-1 cycles.
- Register i is cleared at edge k+i, where k is the edge that samples clr_req.
- The first write accepted after a clear is at edge k+NREG.
- The counter is AW bits wide and never wraps; it stops at NREG-1.

## Structure
- Shared package regfile_pkg:
  - FSM state encoding: IDLE=1'b0, CLEAR=1'b1.
  - Default XLEN and NREG constants.
- Sub-module regfile_clr_seq: FSM plus counter.
  - Inputs: clk, rst_n, clr_req.
  - Outputs: clr_busy, clr_we, clr_addr.
  - The top level muxes clr_we/clr_addr/INIVAL against we/waddr/wdata onto the storage array.
- Storage is a flat reg array [1:NREG-1]; no entry is declared for address 0.

## Test plan
- Reset then read all addresses on both ports -> address 0 returns 0, all others return INIVAL; clr_busy=0.
- Write 0xDEADBEEF to x5, read x5 on port 1 in the same cycle:
  - BYPASS=1 -> 0xDEADBEEF in the same cycle.
  - BYPASS=0 -> old value that cycle, 0xDEADBEEF the next cycle.
- Write 0x12345678 to x0 -> rdata1 and rdata2 for address 0 stay 0. Verify with both raddr1 and raddr2 = 0 and a bypass-eligible cycle.
- Fill x1..x31 with their index, pulse clr_req (NREG=32):
  - clr_busy is high for exactly 31 cycles.
  - x3 reads 3 until edge k+3, then reads INIVAL.
  - A we pulse to x7 during clear is dropped; x7 = INIVAL afterwards.
- clr_req and we (x2 <= 0xA5A5A5A5) in the same cycle -> write lands, then x2 = INIVAL after edge k+2.
- Assert rst_n at clear cycle 10 -> clr_busy=0 immediately; all registers = INIVAL. A fresh clr_req afterwards runs the full 31 cycles.
